// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns one local command into one SETUP/ACCESS transfer and
// returns a single response carrying read data, slave error and timeout flags.
module apb_cmd_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]               cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state_q,   state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q,   paddr_d;
    logic [31:0]               pwdata_q,  pwdata_d;
    logic                      pwrite_q,  pwrite_d;
    logic [31:0]               rdata_q,   rdata_d;
    logic                      err_q,     err_d;
    logic                      tmo_q,     tmo_d;
    logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // PREADY on the last allowed cycle still completes normally.
                if (PREADY) begin
                    rdata_d = pwrite_q ? 32'd0 : PRDATA;
                    err_d   = PSLVERR;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (TMO_EN && (wait_cnt_q == CNT_LAST)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes decode straight from state so reset drops them without a clock.
    assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE     = (state_q == ACCESS);
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: table of single transfers plus hand-written
// sequences for timeout, backpressure, back-to-back throughput and async reset.
module tb_apb_cmd_master;

    localparam int AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    apb_cmd_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            waits;
        logic [31:0]   prdata;
        logic          slverr;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        int            exp_rsp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("wait_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Issue one command; PREADY rises on ACCESS cycle index 'waits' and garbage
    // PSLVERR/PRDATA are driven on the preceding wait cycles.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0;
        int acc = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        step(); cyc++;
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        check({tag, "_setup"}, {30'd0, PSEL, PENABLE}, 32'd2);
        check({tag, "_setup_busy"}, {30'd0, busy, cmd_ready}, 32'd2);
        step(); cyc++;
        while (!rsp_valid && acc < 20) begin
            check({tag, "_access"}, {30'd0, PSEL, PENABLE}, 32'd3);
            check({tag, "_paddr"}, {20'd0, PADDR}, {20'd0, v.addr});
            check({tag, "_pwrite"}, {31'd0, PWRITE}, {31'd0, v.wr});
            if (v.wr) check({tag, "_pwdata"}, PWDATA, v.wdata);
            PREADY  = (acc >= v.waits);
            PSLVERR = (acc >= v.waits) ? v.slverr : 1'b1;
            PRDATA  = (acc >= v.waits) ? v.prdata : 32'hBAD0_BAD0;
            step(); cyc++; acc++;
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h5555_AAAA;
        check({tag, "_rsp_cycle"}, cyc, v.exp_rsp_cyc);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rsp_psel"}, {30'd0, PSEL, PENABLE}, 32'd0);
        check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, "_err_tmo"}, {30'd0, rsp_err, rsp_timeout}, {30'd0, v.exp_err, 1'b0});
        step();
        check({tag, "_idle"}, {30'd0, cmd_ready, rsp_valid}, 32'd2);
    endtask

    initial begin
        int acc;
        int setups[$];
        logic [31:0] hold_rdata;

        //            wr    addr     wdata         waits prdata        slverr exp_rdata     err  cyc
        vecs[0] = '{1'b1, 12'h008, 32'h0000_0004, 0, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b0, 3};
        vecs[1] = '{1'b0, 12'h000, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 6};
        vecs[2] = '{1'b1, 12'h010, 32'h1234_5678, 2, 32'h2222_2222, 1'b1, 32'h0000_0000, 1'b1, 5};
        vecs[3] = '{1'b0, 12'h0FC, 32'h0000_0000, 1, 32'hA5A5_5A5A, 1'b1, 32'hA5A5_5A5A, 1'b1, 4};
        vecs[4] = '{1'b0, 12'hFFF, 32'h0000_0000, 7, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 10};
        vecs[5] = '{1'b1, 12'h004, 32'hFFFF_FFFF, 0, 32'h3333_3333, 1'b0, 32'h0000_0000, 1'b0, 3};

        #2 HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_strobes", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
        check("rst_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
        check("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_paddr", {20'd0, PADDR}, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Timeout: PREADY stuck low, expect exactly 8 ACCESS cycles.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h123;
        PREADY = 1'b0; PRDATA = 32'hFEED_FACE;
        step();
        cmd_valid = 1'b0;
        step();
        acc = 0;
        while (PENABLE && acc < 20) begin
            PSLVERR = acc[0];
            step();
            acc++;
        end
        PSLVERR = 1'b0;
        check("tmo_access_cycles", acc, 8);
        check("tmo_psel", {30'd0, PSEL, rsp_valid}, 32'd1);
        check("tmo_flags", {30'd0, rsp_err, rsp_timeout}, 32'd3);
        check("tmo_rdata", rsp_rdata, 32'd0);
        step();
        wait_idle();

        // Backpressure with a new command pending, then back-to-back throughput.
        rsp_ready = 1'b0; PREADY = 1'b1; PRDATA = 32'h0BAD_CAFE;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        hold_rdata = rsp_rdata;
        check("bp_rdata0", hold_rdata, 32'h0BAD_CAFE);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h040; cmd_wdata = 32'hCAFE_F00D;
        PRDATA = 32'h7777_7777;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d", k), {28'd0, rsp_valid, cmd_ready, PSEL, rsp_err}, 32'h8);
            check($sformatf("bp_rdata%0d", k), rsp_rdata, 32'h0BAD_CAFE);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp_idle", {30'd0, cmd_ready, PSEL}, 32'd2);
        step();
        check("b2b_setup", {30'd0, PSEL, PENABLE}, 32'd2);
        check("b2b_paddr", {20'd0, PADDR}, 32'h040);
        check("b2b_pwdata", PWDATA, 32'hCAFE_F00D);
        for (int k = 1; k < 12; k++) begin
            step();
            if (PSEL && !PENABLE) setups.push_back(k);
        end
        check("b2b_count", setups.size(), 2);
        if (setups.size() == 2) begin
            check("b2b_gap1", setups[0], 4);
            check("b2b_gap2", setups[1], 8);
        end
        cmd_valid = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of ACCESS.
        PREADY = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h0AC; cmd_wdata = 32'h1;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_access", {30'd0, PSEL, PENABLE}, 32'd3);
        #2 HRESETn = 1'b0;
        #1;
        check("mid_rst_strobes", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd0);
        check("mid_rst_paddr", {20'd0, PADDR}, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
        check("post_rst_idle", {29'd0, cmd_ready, busy, rsp_valid}, 32'd4);
        step();
        check("post_rst_quiet", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
